// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// State encodings are visible on the debug State port.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET_LOAD = 3'd0,
    ST_FETCH      = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXEC       = 3'd3,
    ST_IRQ_SAVE   = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  localparam int          PC_W      = 16;
  localparam int          INC_BYTES = 2;
  localparam logic [15:0] RESET_VEC = 16'h0000;
  localparam logic [15:0] IRQ_VEC   = 16'h0100;
  localparam bit          IE_RST    = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> sequencer bundle.
// master: decode/control side, slave: the sequencer.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] PCCur;
  logic                Stall;
  logic                JumpReq;
  logic [PC_WIDTH-1:0] JumpTarget;
  logic                BranchReq;
  logic                BranchTaken;
  logic [PC_WIDTH-1:0] BranchTarget;
  logic                RetReq;
  logic                Halt;
  logic                IRQ;
  logic                PCWrite;
  logic [PC_WIDTH-1:0] PCIn;
  logic                IRWrite;
  logic                IRQAck;
  logic [PC_WIDTH-1:0] EPC;
  logic                IE;
  logic [2:0]          State;

  modport master (
    output PCCur, Stall,
    output JumpReq, JumpTarget,
    output BranchReq, BranchTaken,
    output BranchTarget,
    output RetReq, Halt, IRQ,
    input  PCWrite, PCIn, IRWrite,
    input  IRQAck, EPC, IE, State
  );

  modport slave (
    input  PCCur, Stall,
    input  JumpReq, JumpTarget,
    input  BranchReq, BranchTaken,
    input  BranchTarget,
    input  RetReq, Halt, IRQ,
    output PCWrite, PCIn, IRWrite,
    output IRQAck, EPC, IE, State
  );
endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// Next-PC source selection and PC write request.
// Pure combinational; stall/reset gating is done by the caller.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_W,
  parameter int                  INC          = INC_BYTES,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VEC),
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(IRQ_VEC)
) (
  input  state_t              state,
  input  logic [PC_WIDTH-1:0] pc_cur,
  input  logic [PC_WIDTH-1:0] epc,
  input  logic                jump_req,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_req,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                ret_req,
  output logic                pc_write,
  output logic [PC_WIDTH-1:0] pc_in,
  output logic                ret_sel
);

  logic [PC_WIDTH-1:0] pc_seq;

  // Sequential increment wraps modulo 2^PC_WIDTH
  assign pc_seq = pc_cur + PC_WIDTH'(INC);

  always_comb begin
    pc_write = 1'b0;
    pc_in    = pc_seq;
    ret_sel  = 1'b0;
    case (state)
      ST_RESET_LOAD: begin
        pc_write = 1'b1;
        pc_in    = RESET_VECTOR;
      end
      ST_FETCH: begin
        pc_write = 1'b1;
      end
      ST_EXEC: begin
        if (jump_req) begin
          pc_write = 1'b1;
          pc_in    = jump_target;
        end else if (branch_req && branch_taken) begin
          pc_write = 1'b1;
          pc_in    = branch_target;
        end else if (ret_req) begin
          pc_write = 1'b1;
          pc_in    = epc;
          ret_sel  = 1'b1;
        end
      end
      ST_IRQ_SAVE: begin
        pc_write = 1'b1;
        pc_in    = IRQ_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencing FSM with EPC/IE ownership.
// Outputs are combinational from State and the request inputs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_W,
  parameter int                  INC          = INC_BYTES,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VEC),
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(IRQ_VEC),
  parameter bit                  IE_RESET     = IE_RST
) (
  input logic           CLK,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] epc, epc_nx;
  logic                ie, ie_nx;
  logic                ir_wr, ack;
  logic                can_stall, frz;
  logic                mux_wr, ret_sel;
  logic [PC_WIDTH-1:0] mux_pc;

  pc_next_mux #(
    .PC_WIDTH    (PC_WIDTH),
    .INC         (INC),
    .RESET_VECTOR(RESET_VECTOR),
    .IRQ_VECTOR  (IRQ_VECTOR)
  ) u_mux (
    .state        (state),
    .pc_cur       (bus.PCCur),
    .epc          (epc),
    .jump_req     (bus.JumpReq),
    .jump_target  (bus.JumpTarget),
    .branch_req   (bus.BranchReq),
    .branch_taken (bus.BranchTaken),
    .branch_target(bus.BranchTarget),
    .ret_req      (bus.RetReq),
    .pc_write     (mux_wr),
    .pc_in        (mux_pc),
    .ret_sel      (ret_sel)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= ST_RESET_LOAD;
      epc   <= '0;
      ie    <= IE_RESET;
    end else begin
      state <= state_nx;
      epc   <= epc_nx;
      ie    <= ie_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    epc_nx    = epc;
    ie_nx     = ie;
    ir_wr     = 1'b0;
    ack       = 1'b0;
    can_stall = 1'b1;
    case (state)
      ST_RESET_LOAD: state_nx = ST_FETCH;
      ST_FETCH: begin
        ir_wr    = 1'b1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        if (ret_sel) ie_nx = 1'b1;
        // Registered IE: a same-cycle return cannot admit this IRQ
        if (bus.Halt)
          state_nx = ST_HALT;
        else if (bus.IRQ && ie)
          state_nx = ST_IRQ_SAVE;
        else
          state_nx = ST_FETCH;
      end
      ST_IRQ_SAVE: begin
        epc_nx   = bus.PCCur;
        ie_nx    = 1'b0;
        ack      = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: begin
        can_stall = 1'b0;
        if (bus.IRQ && ie) state_nx = ST_IRQ_SAVE;
      end
      default: begin
        can_stall = 1'b0;
        state_nx  = ST_FETCH;
      end
    endcase
    if (bus.Stall && can_stall) begin
      state_nx = state;
      epc_nx   = epc;
      ie_nx    = ie;
      ir_wr    = 1'b0;
      ack      = 1'b0;
    end
  end

  assign frz = bus.Stall & can_stall;

  assign bus.PCWrite = Reset & ~frz & mux_wr;
  assign bus.PCIn    = Reset ? mux_pc : '0;
  assign bus.IRWrite = Reset & ir_wr;
  assign bus.IRQAck  = Reset & ack;
  assign bus.EPC     = epc;
  assign bus.IE      = ie;
  assign bus.State   = state;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM for the accumulator processor's program counter. It generates the PC write strobe and next-PC value for the PC register, and the instruction-register write strobe. Next-PC sources are: reset vector, sequential increment, jump, taken branch, interrupt vector, and return-from-interrupt. The block sits between the decode/control unit and the PC register, and owns the saved-PC (EPC) and interrupt-enable state.

Parameters:
PC_WIDTH, 16, width of all PC values
INC, 2, sequential PC increment in bytes
RESET_VECTOR, 16'h0000, PC loaded in the first cycle after reset
IRQ_VECTOR, 16'h0100, PC loaded on interrupt entry
IE_RESET, 1, interrupt-enable value after reset

Ports:
CLK  in  1  clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset (Reset==0 resets)
PCCur  in  PC_WIDTH  current PC register output
Stall  in  1  freeze sequencing this cycle
JumpReq  in  1  unconditional jump (sampled in EXEC)
JumpTarget  in  PC_WIDTH  jump destination
BranchReq  in  1  conditional branch instruction (sampled in EXEC)
BranchTaken  in  1  branch condition result
BranchTarget  in  PC_WIDTH  branch destination
RetReq  in  1  return-from-interrupt (sampled in EXEC)
Halt  in  1  halt after current instruction (sampled in EXEC)
IRQ  in  1  level interrupt request
PCWrite  out  1  PC register load strobe
PCIn  out  PC_WIDTH  next PC value
IRWrite  out  1  instruction register load strobe
IRQAck  out  1  one-cycle interrupt acknowledge
EPC  out  PC_WIDTH  saved return PC
IE  out  1  interrupt enable
State  out  3  FSM state, for debug

Behaviour:
- State encodings: RESET_LOAD=0, FETCH=1, DECODE=2, EXEC=3, IRQ_SAVE=4, HALT=5. Codes 6 and 7 are illegal and go to FETCH on the next edge.
- While Reset==0, asynchronously: State=RESET_LOAD, EPC=0, IE=IE_RESET. All strobes (PCWrite, IRWrite, IRQAck) are forced to 0 and PCIn=0. This applies mid-instruction too: any in-flight operation is abandoned.
- Outputs are combinational from State and the inputs. Registers are State, EPC and IE only.
- Stall=1 in any state except HALT:
  - all strobes are 0;
  - State, EPC and IE hold;
  - PCIn holds the value it would otherwise present.
- RESET_LOAD: PCWrite=1, PCIn=RESET_VECTOR; next state FETCH.
- FETCH:
  - IRWrite=1, PCWrite=1;
  - PCIn=(PCCur+INC) mod 2^PC_WIDTH, so 16'hFFFE+2 wraps to 16'h0000 with no flag;
  - next state DECODE.
- DECODE: no strobes; next state EXEC. The decode unit settles its requests here.
- EXEC, next-PC priority:
  - JumpReq: PCWrite=1, PCIn=JumpTarget.
  - Else BranchReq&BranchTaken: PCWrite=1, PCIn=BranchTarget. A not-taken branch writes nothing.
  - Else RetReq: PCWrite=1, PCIn=EPC; IE<=1 at the edge.
  - Otherwise PCWrite=0.
  - When Jump or Branch wins over a concurrent RetReq, IE does not change.
- EXEC, next-state priority (evaluated independently of the next-PC choice):
  - Halt → HALT;
  - else IRQ&IE → IRQ_SAVE (IE is the registered value, so a RetReq in the same EXEC does not enable this IRQ);
  - else → FETCH.
- IRQ_SAVE:
  - EPC<=PCCur, which is the PC already updated by FETCH/EXEC (the next instruction);
  - PCWrite=1, PCIn=IRQ_VECTOR, IRQAck=1, IE<=0;
  - next state FETCH. IRQ deasserting in this cycle does not abort entry.
- HALT:
  - no strobes; Stall is ignored;
  - IRQ&IE → IRQ_SAVE; otherwise stay in HALT.
  - Only reset or an interrupt exits HALT. EPC then holds the instruction after the halt.
- Latency: a non-branching instruction takes 3 cycles (FETCH, DECODE, EXEC). A taken interrupt adds 1 cycle.

Decomposition:
- Shared package holds:
  - state encodings and the 3-bit state type;
  - RESET_VECTOR and IRQ_VECTOR defaults;
  - the INC constant.
- One combinational sub-module, pc_next_mux, holds the priority selection of PCIn and PCWrite from state and requests. The top level keeps the FSM, EPC and IE registers.

Test Plan:
- Reset held low then released → first edge: PCWrite=1, PCIn=16'h0000; then FETCH with IRWrite=1. Reset low mid-EXEC → State=0 and strobes 0 immediately, without waiting for a clock edge.
- PCCur=16'h0010, no requests → FETCH PCIn=16'h0012; EXEC PCWrite=0; back to FETCH after 3 cycles. PCCur=16'hFFFE → PCIn=16'h0000.
- EXEC with JumpReq=1 (JumpTarget=16'h0200) and BranchReq=BranchTaken=1 (BranchTarget=16'h0040) → PCIn=16'h0200. Branch alone → 16'h0040. BranchTaken=0 → PCWrite=0.
- IE=1, IRQ=1 in EXEC, PCCur=16'h0024 at IRQ_SAVE → EPC=16'h0024, PCIn=16'h0100, IRQAck high for exactly 1 cycle, IE=0. A later EXEC with RetReq → PCIn=16'h0024, IE=1.
- Stall=1 for 3 cycles during DECODE → State stays 2 and strobes stay 0; sequencing resumes unchanged after Stall drops.
- Halt in EXEC → HALT; Stall toggling has no effect. IRQ with IE=0 → stays in HALT. IRQ with IE=1 → IRQ_SAVE, then FETCH at 16'h0100.
